// File: rtl/xif_commit_tracker_if.sv
// ----------------------------------------------------------------------------
// xif_commit_tracker_if
//
// Bundles the issue snoop, commit, execution-result and result-port signals
// seen by xif_commit_tracker.
//
// Modports:
//   slave  - the tracker itself (consumes issue/commit/ex/result_ready, drives
//            busy, ex_ready, result fields, outstanding count, error pulse)
//   master - the environment around it (core + execution unit)
//
// Signal names keep their directional suffix as seen from the tracker so that
// they read the same at both ends.
// ----------------------------------------------------------------------------
interface xif_commit_tracker_if #(
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned X_RFW_WIDTH = 32
);

  // Issue snoop
  logic                   issue_valid_i;
  logic                   issue_ready_i;
  logic                   issue_accept_i;
  logic [X_ID_WIDTH-1:0]  issue_id_i;
  logic                   issue_id_busy_o;

  // Commit
  logic                   commit_valid_i;
  logic [X_ID_WIDTH-1:0]  commit_id_i;
  logic                   commit_kill_i;

  // Execution unit result
  logic                   ex_valid_i;
  logic                   ex_ready_o;
  logic [X_ID_WIDTH-1:0]  ex_id_i;
  logic [X_RFW_WIDTH-1:0] ex_data_i;
  logic [4:0]             ex_rd_i;
  logic                   ex_we_i;

  // Result port toward the core
  logic                   result_valid_o;
  logic                   result_ready_i;
  logic [X_ID_WIDTH-1:0]  result_id_o;
  logic [X_RFW_WIDTH-1:0] result_data_o;
  logic [4:0]             result_rd_o;
  logic                   result_we_o;

  // Status
  logic [X_ID_WIDTH:0]    outstanding_o;
  logic                   proto_err_o;

  modport slave (
    input  issue_valid_i,
    input  issue_ready_i,
    input  issue_accept_i,
    input  issue_id_i,
    output issue_id_busy_o,
    input  commit_valid_i,
    input  commit_id_i,
    input  commit_kill_i,
    input  ex_valid_i,
    output ex_ready_o,
    input  ex_id_i,
    input  ex_data_i,
    input  ex_rd_i,
    input  ex_we_i,
    output result_valid_o,
    input  result_ready_i,
    output result_id_o,
    output result_data_o,
    output result_rd_o,
    output result_we_o,
    output outstanding_o,
    output proto_err_o
  );

  modport master (
    output issue_valid_i,
    output issue_ready_i,
    output issue_accept_i,
    output issue_id_i,
    input  issue_id_busy_o,
    output commit_valid_i,
    output commit_id_i,
    output commit_kill_i,
    output ex_valid_i,
    input  ex_ready_o,
    output ex_id_i,
    output ex_data_i,
    output ex_rd_i,
    output ex_we_i,
    input  result_valid_o,
    output result_ready_i,
    input  result_id_o,
    input  result_data_o,
    input  result_rd_o,
    input  result_we_o,
    input  outstanding_o,
    input  proto_err_o
  );

endinterface

// File: rtl/xif_commit_tracker.sv
// ----------------------------------------------------------------------------
// xif_commit_tracker
//
// Coprocessor-side stage behind the CV-X-IF issue/commit ports and in front of
// the result port. Every accepted offloaded instruction is tracked by ID
// through issue, commit/kill and execution completion. Execution results are
// held back until their instruction is committed; results of killed
// instructions are dropped. Committed results go to the core through a
// single-entry output register.
//
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset
//   xif     - slave modport of xif_commit_tracker_if:
//             issue_*   snooped issue handshake, issue_id_busy_o back-pressure
//             commit_*  commit strobe with kill flag
//             ex_*      result handshake from the execution unit
//             result_*  result handshake toward the core
//             outstanding_o  number of non-free IDs
//             proto_err_o    one-cycle pulse on a protocol violation
// ----------------------------------------------------------------------------
module xif_commit_tracker #(
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned X_RFW_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  xif_commit_tracker_if.slave  xif
);

  localparam int unsigned NumIds = 2 ** X_ID_WIDTH;

  typedef enum logic [1:0] {
    StFree      = 2'd0,
    StIssued    = 2'd1,
    StCommitted = 2'd2,
    StKilled    = 2'd3
  } entry_state_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  entry_state_e           state_q [NumIds];
  entry_state_e           state_d [NumIds];

  logic [X_ID_WIDTH:0]    outstanding_q, outstanding_d;
  logic                   proto_err_q, proto_err_d;

  logic                   result_valid_q, result_valid_d;
  logic [X_ID_WIDTH-1:0]  result_id_q, result_id_d;
  logic [X_RFW_WIDTH-1:0] result_data_q, result_data_d;
  logic [4:0]             result_rd_q, result_rd_d;
  logic                   result_we_q, result_we_d;

  // --------------------------------------------------------------------------
  // Event decode (all from registered entry state)
  // --------------------------------------------------------------------------
  entry_state_e issue_state, commit_state, ex_state;

  logic issue_fire, issue_ok, issue_err;
  logic commit_ok, commit_err;
  logic ex_ready, ex_fire, ex_load, ex_free, ex_err;

  always_comb begin
    issue_state  = state_q[xif.issue_id_i];
    commit_state = state_q[xif.commit_id_i];
    ex_state     = state_q[xif.ex_id_i];
  end

  // Issue: only a FREE entry may be (re)allocated. A handshake that completes
  // against a busy ID (including one being freed this very cycle) is an error.
  always_comb begin
    issue_fire = xif.issue_valid_i & xif.issue_ready_i & xif.issue_accept_i;
    issue_ok   = issue_fire & (issue_state == StFree);
    issue_err  = issue_fire & (issue_state != StFree);
  end

  always_comb begin
    commit_ok  = xif.commit_valid_i & (commit_state == StIssued);
    commit_err = xif.commit_valid_i & (commit_state != StIssued);
  end

  // ex_ready: committed results wait for room in the output register, killed
  // and unknown (FREE) results are swallowed, uncommitted ones stall. Because
  // this looks at registered state, a commit in the same cycle as its ex
  // result still stalls that result for one cycle.
  always_comb begin
    ex_ready = 1'b1;
    unique case (ex_state)
      StFree:      ex_ready = 1'b1;
      StIssued:    ex_ready = 1'b0;
      StCommitted: ex_ready = ~result_valid_q | xif.result_ready_i;
      StKilled:    ex_ready = 1'b1;
      default:     ex_ready = 1'b1;
    endcase
  end

  always_comb begin
    ex_fire = xif.ex_valid_i & ex_ready;
    ex_load = ex_fire & (ex_state == StCommitted);
    ex_free = ex_fire & ((ex_state == StCommitted) | (ex_state == StKilled));
    ex_err  = ex_fire & (ex_state == StFree);
  end

  // --------------------------------------------------------------------------
  // Entry table next state
  // --------------------------------------------------------------------------
  // The three updates never legally target the same entry in one cycle: each
  // one requires a distinct source state, and the losers are flagged as
  // errors and not applied.
  always_comb begin
    for (int i = 0; i < NumIds; i++) begin
      state_d[i] = state_q[i];
    end
    if (ex_free) begin
      state_d[xif.ex_id_i] = StFree;
    end
    if (commit_ok) begin
      state_d[xif.commit_id_i] = xif.commit_kill_i ? StKilled : StCommitted;
    end
    if (issue_ok) begin
      state_d[xif.issue_id_i] = StIssued;
    end
  end

  // Count moves by at most +1/-1 and mirrors the number of non-FREE entries,
  // so it stays within 0..NumIds by construction.
  always_comb begin
    outstanding_d = outstanding_q
                  + {{X_ID_WIDTH{1'b0}}, issue_ok}
                  - {{X_ID_WIDTH{1'b0}}, ex_free};
  end

  always_comb begin
    proto_err_d = issue_err | commit_err | ex_err;
  end

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  // ex_load is only possible when the register is empty or draining this
  // cycle, which gives full throughput for back-to-back results.
  always_comb begin
    result_valid_d = result_valid_q;
    result_id_d    = result_id_q;
    result_data_d  = result_data_q;
    result_rd_d    = result_rd_q;
    result_we_d    = result_we_q;
    if (ex_load) begin
      result_valid_d = 1'b1;
      result_id_d    = xif.ex_id_i;
      result_data_d  = xif.ex_data_i;
      result_rd_d    = xif.ex_rd_i;
      result_we_d    = xif.ex_we_i;
    end else if (xif.result_ready_i) begin
      result_valid_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumIds; i++) begin
        state_q[i] <= StFree;
      end
      outstanding_q  <= '0;
      proto_err_q    <= 1'b0;
      result_valid_q <= 1'b0;
      result_id_q    <= '0;
      result_data_q  <= '0;
      result_rd_q    <= '0;
      result_we_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NumIds; i++) begin
        state_q[i] <= state_d[i];
      end
      outstanding_q  <= outstanding_d;
      proto_err_q    <= proto_err_d;
      result_valid_q <= result_valid_d;
      result_id_q    <= result_id_d;
      result_data_q  <= result_data_d;
      result_rd_q    <= result_rd_d;
      result_we_q    <= result_we_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign xif.issue_id_busy_o = (issue_state != StFree);
  assign xif.ex_ready_o      = ex_ready;
  assign xif.result_valid_o  = result_valid_q;
  assign xif.result_id_o     = result_id_q;
  assign xif.result_data_o   = result_data_q;
  assign xif.result_rd_o     = result_rd_q;
  assign xif.result_we_o     = result_we_q;
  assign xif.outstanding_o   = outstanding_q;
  assign xif.proto_err_o     = proto_err_q;

endmodule

// File: tb/tb_xif_commit_tracker.sv
// ----------------------------------------------------------------------------
// tb_xif_commit_tracker
//
// Self-checking bench for xif_commit_tracker. Expected results are queued when
// an ex handshake of a committed ID is seen and compared by a monitor when the
// core side takes a result. Inputs change 1ns after the rising edge; checks
// happen 4ns after it; the monitor samples on the falling edge.
// ----------------------------------------------------------------------------
module tb_xif_commit_tracker;

  localparam int unsigned IdW  = 4;
  localparam int unsigned RfwW = 32;

  typedef struct packed {
    logic [IdW-1:0]  id;
    logic [RfwW-1:0] data;
    logic [4:0]      rd;
    logic            we;
  } res_t;

  logic clk_i;
  logic rst_ni;

  int n_checks;
  int n_fail;

  res_t exp_q[$];

  xif_commit_tracker_if #(.X_ID_WIDTH(IdW), .X_RFW_WIDTH(RfwW)) bus ();

  xif_commit_tracker #(
    .X_ID_WIDTH (IdW),
    .X_RFW_WIDTH(RfwW)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .xif   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Result scoreboard
  always @(negedge clk_i) begin
    if (rst_ni && bus.result_valid_o === 1'b1 && bus.result_ready_i === 1'b1) begin
      res_t got;
      res_t exp;
      got = '{id: bus.result_id_o, data: bus.result_data_o, rd: bus.result_rd_o,
              we: bus.result_we_o};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL result_unexpected: got id=%0d data=%h rd=%0d we=%0d, required none",
                 got.id, got.data, got.rd, got.we);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL result_fields: got id=%0d data=%h rd=%0d we=%0d, required id=%0d data=%h rd=%0d we=%0d",
                   got.id, got.data, got.rd, got.we, exp.id, exp.data, exp.rd, exp.we);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Drivers (all start and end 1ns after a rising edge)
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    #3;
  endtask

  task automatic do_issue(input logic [IdW-1:0] id);
    bus.issue_valid_i  = 1'b1;
    bus.issue_ready_i  = 1'b1;
    bus.issue_accept_i = 1'b1;
    bus.issue_id_i     = id;
    step();
    bus.issue_valid_i  = 1'b0;
  endtask

  task automatic do_commit(input logic [IdW-1:0] id, input logic kill);
    bus.commit_valid_i = 1'b1;
    bus.commit_id_i    = id;
    bus.commit_kill_i  = kill;
    step();
    bus.commit_valid_i = 1'b0;
    bus.commit_kill_i  = 1'b0;
  endtask

  task automatic drive_ex(input logic [IdW-1:0] id, input logic [RfwW-1:0] data,
                          input logic [4:0] rd, input logic we);
    bus.ex_valid_i = 1'b1;
    bus.ex_id_i    = id;
    bus.ex_data_i  = data;
    bus.ex_rd_i    = rd;
    bus.ex_we_i    = we;
  endtask

  // Present an ex result and wait (bounded) for acceptance.
  task automatic do_ex(input logic [IdW-1:0] id, input logic [RfwW-1:0] data,
                       input logic [4:0] rd, input logic we, input bit expect_res);
    bit accepted;
    accepted = 1'b0;
    drive_ex(id, data, rd, we);
    for (int c = 0; c < 20 && !accepted; c++) begin
      mid();
      if (bus.ex_ready_o === 1'b1) begin
        accepted = 1'b1;
        if (expect_res) exp_q.push_back('{id: id, data: data, rd: rd, we: we});
      end
      step();
    end
    bus.ex_valid_i = 1'b0;
    n_checks++;
    if (!accepted) begin
      n_fail++;
      $display("FAIL ex_accept_timeout: id=%0d got ex_ready_o=0 for 20 cycles, required 1", id);
    end
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    mid();
    n_checks++;
    if ({bus.result_valid_o, bus.outstanding_o, bus.proto_err_o, bus.issue_id_busy_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_flags: got valid=%b outstanding=%0d err=%b busy=%b, required all 0",
               bus.result_valid_o, bus.outstanding_o, bus.proto_err_o, bus.issue_id_busy_o);
    end
    n_checks++;
    if ({bus.result_id_o, bus.result_data_o, bus.result_rd_o, bus.result_we_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_fields: got id=%0d data=%h rd=%0d we=%b, required all 0",
               bus.result_id_o, bus.result_data_o, bus.result_rd_o, bus.result_we_o);
    end
    step();
  endtask

  task automatic test_basic();
    do_issue(4'd3);
    mid();
    n_checks++;
    if (bus.outstanding_o !== 5'd1 || bus.issue_id_busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_issued: got outstanding=%0d busy=%b, required 1 and 1",
               bus.outstanding_o, bus.issue_id_busy_o);
    end
    step();
    do_commit(4'd3, 1'b0);
    drive_ex(4'd3, 32'hDEADBEEF, 5'd5, 1'b1);
    mid();
    n_checks++;
    if (bus.ex_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ex_ready: got %b, required 1", bus.ex_ready_o);
    end
    exp_q.push_back('{id: 4'd3, data: 32'hDEADBEEF, rd: 5'd5, we: 1'b1});
    step();
    bus.ex_valid_i = 1'b0;
    mid();
    n_checks++;
    if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== 4'd3 || bus.outstanding_o !== 5'd0) begin
      n_fail++;
      $display("FAIL basic_result: got valid=%b id=%0d outstanding=%0d, required 1, 3, 0",
               bus.result_valid_o, bus.result_id_o, bus.outstanding_o);
    end
    step();
  endtask

  task automatic test_stall_until_commit();
    do_issue(4'd2);
    drive_ex(4'd2, 32'h12345678, 5'd10, 1'b1);
    for (int c = 0; c < 4; c++) begin
      mid();
      n_checks++;
      if (bus.ex_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_ex_ready cycle %0d: got %b, required 0", c, bus.ex_ready_o);
      end
      step();
    end
    // Commit lands while ex is waiting: still stalled this cycle.
    bus.commit_valid_i = 1'b1;
    bus.commit_id_i    = 4'd2;
    bus.commit_kill_i  = 1'b0;
    mid();
    n_checks++;
    if (bus.ex_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_same_cycle_commit: got ex_ready=%b, required 0", bus.ex_ready_o);
    end
    step();
    bus.commit_valid_i = 1'b0;
    mid();
    n_checks++;
    if (bus.ex_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_after_commit: got ex_ready=%b, required 1", bus.ex_ready_o);
    end
    exp_q.push_back('{id: 4'd2, data: 32'h12345678, rd: 5'd10, we: 1'b1});
    step();
    bus.ex_valid_i = 1'b0;
    mid();
    n_checks++;
    if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== 4'd2) begin
      n_fail++;
      $display("FAIL stall_result: got valid=%b id=%0d, required 1 and 2",
               bus.result_valid_o, bus.result_id_o);
    end
    step();
  endtask

  task automatic test_kill();
    do_issue(4'd7);
    do_commit(4'd7, 1'b1);
    drive_ex(4'd7, 32'hCAFEF00D, 5'd7, 1'b1);
    mid();
    n_checks++;
    if (bus.ex_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL kill_ex_ready: got %b, required 1", bus.ex_ready_o);
    end
    step();
    bus.ex_valid_i = 1'b0;
    bus.issue_id_i = 4'd7;
    mid();
    n_checks++;
    if ({bus.result_valid_o, bus.outstanding_o, bus.proto_err_o, bus.issue_id_busy_o} !== '0) begin
      n_fail++;
      $display("FAIL kill_dropped: got valid=%b outstanding=%0d err=%b busy=%b, required all 0",
               bus.result_valid_o, bus.outstanding_o, bus.proto_err_o, bus.issue_id_busy_o);
    end
    step();
  endtask

  task automatic test_backpressure();
    bus.result_ready_i = 1'b0;
    do_issue(4'd1);
    do_commit(4'd1, 1'b0);
    do_ex(4'd1, 32'hA5A50001, 5'd1, 1'b1, 1'b1);
    do_issue(4'd4);
    do_commit(4'd4, 1'b0);
    drive_ex(4'd4, 32'h0BADF00D, 5'd31, 1'b0);
    for (int c = 0; c < 3; c++) begin
      mid();
      n_checks++;
      if (bus.ex_ready_o !== 1'b0 || bus.result_valid_o !== 1'b1 || bus.result_id_o !== 4'd1 ||
          bus.result_data_o !== 32'hA5A50001 || bus.result_rd_o !== 5'd1) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: got ex_ready=%b valid=%b id=%0d data=%h rd=%0d, required 0 1 1 a5a50001 1",
                 c, bus.ex_ready_o, bus.result_valid_o, bus.result_id_o, bus.result_data_o,
                 bus.result_rd_o);
      end
      step();
    end
    bus.result_ready_i = 1'b1;
    mid();
    n_checks++;
    if (bus.ex_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ex_ready: got %b, required 1", bus.ex_ready_o);
    end
    exp_q.push_back('{id: 4'd4, data: 32'h0BADF00D, rd: 5'd31, we: 1'b0});
    step();
    bus.ex_valid_i = 1'b0;
    mid();
    n_checks++;
    if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== 4'd4) begin
      n_fail++;
      $display("FAIL bp_reload: got valid=%b id=%0d, required 1 and 4",
               bus.result_valid_o, bus.result_id_o);
    end
    step();
  endtask

  task automatic test_full_and_errors();
    for (int i = 0; i < 16; i++) do_issue(IdW'(i));
    mid();
    n_checks++;
    if (bus.outstanding_o !== 5'd16) begin
      n_fail++;
      $display("FAIL full_outstanding: got %0d, required 16", bus.outstanding_o);
    end
    step();
    // Re-issue of a busy ID
    bus.issue_valid_i  = 1'b1;
    bus.issue_ready_i  = 1'b1;
    bus.issue_accept_i = 1'b1;
    bus.issue_id_i     = 4'd0;
    mid();
    n_checks++;
    if (bus.issue_id_busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL full_busy: got %b, required 1", bus.issue_id_busy_o);
    end
    step();
    bus.issue_valid_i = 1'b0;
    mid();
    n_checks++;
    if (bus.proto_err_o !== 1'b1 || bus.outstanding_o !== 5'd16) begin
      n_fail++;
      $display("FAIL reissue_err: got err=%b outstanding=%0d, required 1 and 16",
               bus.proto_err_o, bus.outstanding_o);
    end
    step();
    mid();
    n_checks++;
    if (bus.proto_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reissue_err_width: got %b, required 0", bus.proto_err_o);
    end
    step();
    // Drain: even IDs commit, odd IDs are killed; results stream back-to-back.
    for (int i = 0; i < 16; i++) do_commit(IdW'(i), logic'(i % 2));
    for (int i = 0; i < 16; i++) begin
      do_ex(IdW'(i), RfwW'(32'h1000_0000 + i * 32'h11), 5'(i + 8), logic'(i % 3 == 0),
            (i % 2) == 0);
    end
    mid();
    n_checks++;
    if (bus.outstanding_o !== 5'd0) begin
      n_fail++;
      $display("FAIL drain_outstanding: got %0d, required 0", bus.outstanding_o);
    end
    step();
    do_commit(4'd9, 1'b0);
    mid();
    n_checks++;
    if (bus.proto_err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL commit_free_err: got %b, required 1", bus.proto_err_o);
    end
    step();
    mid();
    n_checks++;
    if (bus.proto_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_free_err_width: got %b, required 0", bus.proto_err_o);
    end
    step();
  endtask

  task automatic test_reset_midflight();
    logic [15:0] busy_vec;
    bus.result_ready_i = 1'b0;
    for (int i = 10; i < 16; i++) do_issue(IdW'(i));
    do_commit(4'd10, 1'b0);
    do_ex(4'd10, 32'h55AA55AA, 5'd3, 1'b1, 1'b1);
    mid();
    n_checks++;
    if (bus.outstanding_o !== 5'd5 || bus.result_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_setup: got outstanding=%0d valid=%b, required 5 and 1",
               bus.outstanding_o, bus.result_valid_o);
    end
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if ({bus.result_valid_o, bus.outstanding_o, bus.proto_err_o, bus.result_id_o,
         bus.result_data_o, bus.result_rd_o, bus.result_we_o} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got valid=%b outstanding=%0d err=%b id=%0d data=%h, required all 0",
               bus.result_valid_o, bus.outstanding_o, bus.proto_err_o, bus.result_id_o,
               bus.result_data_o);
    end
    for (int i = 0; i < 16; i++) begin
      bus.issue_id_i = IdW'(i);
      #1;
      busy_vec[i] = bus.issue_id_busy_o;
    end
    n_checks++;
    if (busy_vec !== 16'h0) begin
      n_fail++;
      $display("FAIL midreset_busy: got %h, required 0000", busy_vec);
    end
    exp_q.delete();
    bus.result_ready_i = 1'b1;
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    mid();
    n_checks++;
    if (bus.outstanding_o !== 5'd0 || bus.result_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_after: got outstanding=%0d valid=%b, required 0 and 0",
               bus.outstanding_o, bus.result_valid_o);
    end
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_ni   = 1'b0;
    bus.issue_valid_i  = 1'b0;
    bus.issue_ready_i  = 1'b0;
    bus.issue_accept_i = 1'b0;
    bus.issue_id_i     = '0;
    bus.commit_valid_i = 1'b0;
    bus.commit_id_i    = '0;
    bus.commit_kill_i  = 1'b0;
    bus.ex_valid_i     = 1'b0;
    bus.ex_id_i        = '0;
    bus.ex_data_i      = '0;
    bus.ex_rd_i        = '0;
    bus.ex_we_i        = 1'b0;
    bus.result_ready_i = 1'b1;

    test_reset();
    test_basic();
    test_stall_until_commit();
    test_kill();
    test_backpressure();
    test_full_and_errors();
    test_reset_midflight();

    repeat (3) step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL results_outstanding: got %0d results never delivered, required 0",
               exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xif_commit_tracker.md
Name: xif_commit_tracker

Overview:
- Coprocessor-side stage that sits directly behind the CV-X-IF issue/commit ports and in front of the result port.
- Tracks every accepted offloaded instruction by ID through issue, commit/kill and execution completion.
- Holds back execution results until the instruction is committed, and drops the results of killed instructions.
- Drives the result handshake toward the core through a single-entry output register.

Parameters:
X_ID_WIDTH, 4, width of instruction ID; table holds 2**X_ID_WIDTH entries
X_RFW_WIDTH, 32, result data width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
issue_valid_i  in  1  snooped issue_valid
issue_ready_i  in  1  snooped issue_ready
issue_accept_i  in  1  snooped issue_resp.accept
issue_id_i  in  X_ID_WIDTH  snooped issue_req.id
issue_id_busy_o  out  1  entry[issue_id_i] not FREE (combinational from registered state); coprocessor must drop issue_ready when set
commit_valid_i  in  1  commit strobe
commit_id_i  in  X_ID_WIDTH  commit.id
commit_kill_i  in  1  commit.commit_kill
ex_valid_i  in  1  execution unit result valid
ex_ready_o  out  1  execution result accepted
ex_id_i  in  X_ID_WIDTH  ID of execution result
ex_data_i  in  X_RFW_WIDTH  write data
ex_rd_i  in  5  destination register
ex_we_i  in  1  register write enable
result_valid_o  out  1  result_valid
result_ready_i  in  1  result_ready
result_id_o  out  X_ID_WIDTH  result.id
result_data_o  out  X_RFW_WIDTH  result.data
result_rd_o  out  5  result.rd
result_we_o  out  1  result.we
outstanding_o  out  X_ID_WIDTH+1  count of non-FREE entries
proto_err_o  out  1  one-cycle pulse on protocol violation

Behaviour:
- Reset (async, rst_ni=0): all entries FREE; result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o, outstanding_o and proto_err_o are 0. Reset mid-operation discards all state and the buffered result.
- Per-entry 2-bit state: FREE, ISSUED, COMMITTED, KILLED.
- Issue event (issue_valid_i & issue_ready_i & issue_accept_i):
  - Entry FREE: entry -> ISSUED.
  - Entry not FREE: ignored, proto_err_o pulses.
- Commit event (commit_valid_i):
  - Entry ISSUED, kill=0: -> COMMITTED.
  - Entry ISSUED, kill=1: -> KILLED.
  - Any other state: ignored, proto_err_o pulses.
- Execution unit contract: it returns exactly one ex result per accepted instruction, including killed ones.
- ex_ready_o (computed from registered state):
  - COMMITTED entry: 1 when (!result_valid_o | result_ready_i).
  - KILLED entry: always 1.
  - ISSUED entry: 0 (stall until commit).
  - FREE entry: 1; proto_err_o pulses and the result is dropped.
- ex handshake:
  - COMMITTED: load output register and set entry -> FREE. result_valid_o rises the next cycle (latency 1).
  - KILLED: drop the result, entry -> FREE.
- Output register: holds its contents stable while result_valid_o & !result_ready_i. Back-to-back results give full throughput (load while draining).
- Simultaneous events:
  - Commit and ex for the same ID in one cycle: ex sees the pre-commit state (ISSUED) and stalls; it is accepted the next cycle.
  - Issue and ex-free of the same ID in one cycle: issue_id_busy_o is still 1, so the core re-offers the ID later. If the issue handshake nonetheless completes, it is flagged as an error.
  - Issue, commit and ex events on different IDs in the same cycle are all applied.
- outstanding_o: registered count of non-FREE entries, range 0..2**X_ID_WIDTH. Updated by +issue -free each cycle, never wraps.
- proto_err_o: OR of the error conditions above, registered, one cycle wide.

Test Plan:
- Issue id 3, commit id 3 kill=0, ex id 3 data 0xDEADBEEF rd 5 we 1 -> ex_ready_o=1; next cycle result_valid_o=1, id 3, data 0xDEADBEEF, rd 5; outstanding_o goes 1 -> 0 after the ex handshake.
- Issue id 2, ex id 2 presented before commit -> ex_ready_o=0 for 4 cycles; commit id 2 -> ex accepted the following cycle, result_valid_o 1 cycle later.
- Issue id 7, commit id 7 kill=1, ex id 7 -> ex_ready_o=1, result_valid_o stays 0, entry FREE, outstanding_o=0, proto_err_o=0.
- Hold result_ready_i=0 with result id 1 pending, commit ex id 4 -> ex_ready_o=0 and result fields stable; raise result_ready_i -> id 1 drains and id 4 loads in the same cycle.
- Issue all 16 IDs -> outstanding_o=16 with no wrap; re-issue id 0 -> issue_id_busy_o=1, proto_err_o pulses once; commit to FREE id 9 after draining -> proto_err_o pulses.
- Assert rst_ni=0 mid-flight with 5 outstanding and result_valid_o=1 -> all outputs 0 immediately, issue_id_busy_o=0 for every ID.
